// File: rtl/cache_fill_ctrl.sv
// Cache miss controller: optional dirty-victim write-back, word-counted line fill from
// main memory, then a single-cycle tag/valid commit.
module cache_fill_ctrl #(
    parameter  int ADDR_W = 16,
    parameter  int DATA_W = 16,
    parameter  int WORDS  = 8,
    parameter  int OFF_W  = 1,
    localparam int IDX_W  = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_address,
    input  logic [DATA_W-1:0] victim_data,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              fsm_busy,
    output logic              mem_read_req,
    output logic              mem_write_req,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] memory_wdata,
    output logic [IDX_W-1:0]  data_array_word_idx,
    output logic              write_data_array,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array
);

    localparam logic [IDX_W:0]    LP_WORDS     = (IDX_W+1)'(WORDS);
    localparam logic [IDX_W:0]    LP_LAST      = (IDX_W+1)'(WORDS - 1);
    localparam logic [ADDR_W-1:0] LP_LINE_MASK = ADDR_W'((1 << (IDX_W + OFF_W)) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVICT,
        ST_FILL,
        ST_COMMIT
    } state_t;

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_miss_addr, w_miss_addr_nx;
    logic [ADDR_W-1:0] r_victim_addr, w_victim_addr_nx;
    logic [IDX_W:0]    r_ev_cnt, w_ev_cnt_nx;
    logic [IDX_W:0]    r_req_cnt, w_req_cnt_nx;
    logic [IDX_W:0]    r_rcv_cnt, w_rcv_cnt_nx;
    logic [ADDR_W-1:0] w_miss_base;
    logic [ADDR_W-1:0] w_victim_base;

    assign w_miss_base   = r_miss_addr & ~LP_LINE_MASK;
    assign w_victim_base = r_victim_addr & ~LP_LINE_MASK;
    assign fill_data     = memory_data;
    assign fsm_busy      = (r_state != ST_IDLE) || miss_detected;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [IDX_W-1:0]  idx);
        return base | (ADDR_W'(idx) << OFF_W);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_miss_addr   <= '0;
            r_victim_addr <= '0;
            r_ev_cnt      <= '0;
            r_req_cnt     <= '0;
            r_rcv_cnt     <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_miss_addr   <= w_miss_addr_nx;
            r_victim_addr <= w_victim_addr_nx;
            r_ev_cnt      <= w_ev_cnt_nx;
            r_req_cnt     <= w_req_cnt_nx;
            r_rcv_cnt     <= w_rcv_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx          = r_state;
        w_miss_addr_nx      = r_miss_addr;
        w_victim_addr_nx    = r_victim_addr;
        w_ev_cnt_nx         = r_ev_cnt;
        w_req_cnt_nx        = r_req_cnt;
        w_rcv_cnt_nx        = r_rcv_cnt;
        mem_read_req        = 1'b0;
        mem_write_req       = 1'b0;
        write_data_array    = 1'b0;
        write_tag_array     = 1'b0;
        memory_address      = miss_address;
        memory_wdata        = '0;
        data_array_word_idx = '0;

        case (r_state)
            ST_IDLE: begin
                if (miss_detected) begin
                    w_miss_addr_nx   = miss_address;
                    w_victim_addr_nx = victim_address;
                    w_ev_cnt_nx      = '0;
                    w_req_cnt_nx     = '0;
                    w_rcv_cnt_nx     = '0;
                    w_state_nx       = victim_dirty ? ST_EVICT : ST_FILL;
                end
            end
            ST_EVICT: begin
                mem_write_req       = 1'b1;
                data_array_word_idx = r_ev_cnt[IDX_W-1:0];
                memory_address      = word_addr(w_victim_base, r_ev_cnt[IDX_W-1:0]);
                memory_wdata        = victim_data;
                w_ev_cnt_nx         = r_ev_cnt + 1'b1;
                if (r_ev_cnt == LP_LAST) w_state_nx = ST_FILL;
            end
            ST_FILL: begin
                memory_address      = w_miss_base;
                data_array_word_idx = r_rcv_cnt[IDX_W-1:0];
                if (r_req_cnt < LP_WORDS) begin
                    mem_read_req   = 1'b1;
                    memory_address = word_addr(w_miss_base, r_req_cnt[IDX_W-1:0]);
                    w_req_cnt_nx   = r_req_cnt + 1'b1;
                end
                // A valid with nothing outstanding is dropped without touching the counters.
                if (memory_data_valid && (r_rcv_cnt < r_req_cnt)) begin
                    write_data_array = 1'b1;
                    w_rcv_cnt_nx     = r_rcv_cnt + 1'b1;
                    if (r_rcv_cnt == LP_LAST) w_state_nx = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                write_tag_array = 1'b1;
                memory_address  = w_miss_base;
                w_state_nx      = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: stimulus pushes expected memory/array events,
// a negedge monitor pops and compares them as the DUT strobes.
`timescale 1ns/1ps
module tb_cache_fill_ctrl;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int WORDS = 8;
    localparam int OFF = 1;
    localparam logic [15:0] LMASK = 16'((WORDS << OFF) - 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          miss_detected, victim_dirty, memory_data_valid;
    logic [AW-1:0] miss_address, victim_address;
    logic [DW-1:0] victim_data, memory_data;
    logic          fsm_busy, mem_read_req, mem_write_req, write_data_array, write_tag_array;
    logic [AW-1:0] memory_address;
    logic [DW-1:0] memory_wdata, fill_data;
    logic [2:0]    data_array_word_idx;

    logic          d4_miss, d4_dirty, d4_valid;
    logic [AW-1:0] d4_maddr, d4_vaddr;
    logic [DW-1:0] d4_vdata, d4_mdata;
    logic          d4_busy, d4_rd, d4_wr, d4_wda, d4_tag;
    logic [AW-1:0] d4_addr;
    logic [DW-1:0] d4_wdata, d4_fill;
    logic [1:0]    d4_idx;

    logic [15:0] vsalt = 16'h0;
    logic [15:0] msalt = 16'h0;
    assign victim_data = vsalt + 16'(data_array_word_idx) * 16'h0111;
    assign d4_vdata = 16'h0;

    cache_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WORDS(WORDS), .OFF_W(OFF)) u_dut (
        .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
        .victim_dirty(victim_dirty), .victim_address(victim_address), .victim_data(victim_data),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data), .fsm_busy(fsm_busy),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .memory_address(memory_address), .memory_wdata(memory_wdata),
        .data_array_word_idx(data_array_word_idx), .write_data_array(write_data_array),
        .fill_data(fill_data), .write_tag_array(write_tag_array));

    cache_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WORDS(4), .OFF_W(1)) u_dut4 (
        .clk(clk), .rst(rst), .miss_detected(d4_miss), .miss_address(d4_maddr),
        .victim_dirty(d4_dirty), .victim_address(d4_vaddr), .victim_data(d4_vdata),
        .memory_data_valid(d4_valid), .memory_data(d4_mdata), .fsm_busy(d4_busy),
        .mem_read_req(d4_rd), .mem_write_req(d4_wr), .memory_address(d4_addr),
        .memory_wdata(d4_wdata), .data_array_word_idx(d4_idx), .write_data_array(d4_wda),
        .fill_data(d4_fill), .write_tag_array(d4_tag));

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        int          c;
    } ev_t;
    typedef struct {
        logic [15:0] a;
        int          due;
    } pend_t;

    ev_t   q_wr[$], q_rd[$], q_aw[$];
    int    q_tag[$];
    pend_t q_pend[$];

    int cyc = 0;
    int base = 0;
    int lat = 1;
    bit bubble = 1'b0;
    bit stray = 1'b0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mfun(input logic [15:0] a);
        return 16'(a * 16'h03B1) ^ msalt;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (rel cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: strobe with no expected event (rel cycle %0d)", name, cyc - base);
    endtask

    // Memory model: read requests return in order after lat cycles, optionally only on odd cycles.
    always @(posedge clk) begin
        pend_t p;
        #1;
        memory_data_valid = 1'b0;
        if (rst) begin
            if (stray) begin
                memory_data_valid = 1'b1;
                memory_data = 16'($urandom);
            end else if (q_pend.size() > 0 && q_pend[0].due <= cyc && (!bubble || (cyc % 2) == 1)) begin
                p = q_pend.pop_front();
                memory_data_valid = 1'b1;
                memory_data = mfun(p.a);
            end
        end
    end

    always @(negedge clk) begin
        ev_t e;
        int  rel;
        int  tc;
        rel = cyc - base;
        if (rst) begin
            if (mem_read_req) begin
                pend_t p;
                p.a = memory_address;
                p.due = cyc + lat;
                q_pend.push_back(p);
                if (q_rd.size() == 0) unexpected("rd");
                else begin
                    e = q_rd.pop_front();
                    chk("rd_addr", 32'(memory_address), 32'(e.a));
                    if (e.c >= 0) chk("rd_cycle", 32'(rel), 32'(e.c));
                end
            end
            if (mem_write_req) begin
                if (q_wr.size() == 0) unexpected("wr");
                else begin
                    e = q_wr.pop_front();
                    chk("wr_addr", 32'(memory_address), 32'(e.a));
                    chk("wr_data", 32'(memory_wdata), 32'(e.d));
                    if (e.c >= 0) chk("wr_cycle", 32'(rel), 32'(e.c));
                end
            end
            if (write_data_array) begin
                if (q_aw.size() == 0) unexpected("aw");
                else begin
                    e = q_aw.pop_front();
                    chk("aw_idx", 32'(data_array_word_idx), 32'(e.a));
                    chk("aw_data", 32'(fill_data), 32'(e.d));
                    if (e.c >= 0) chk("aw_cycle", 32'(rel), 32'(e.c));
                end
            end
            if (write_tag_array) begin
                if (q_tag.size() == 0) unexpected("tag");
                else begin
                    tc = q_tag.pop_front();
                    if (tc >= 0) chk("tag_cycle", 32'(rel), 32'(tc));
                    else chk("tag_idle_after", 32'(fsm_busy), 32'(1));
                end
            end
        end
    end

    // Push the whole expected transaction from the miss parameters, then present the miss.
    task automatic start_miss(input logic [15:0] ma, input bit dirty, input logic [15:0] va,
                              input int L, input bit timed, input bit hold);
        logic [15:0] mbase, vbase, wa;
        int off;
        ev_t e;
        lat = L;
        off = dirty ? WORDS : 0;
        mbase = ma & ~LMASK;
        vbase = va & ~LMASK;
        @(posedge clk);
        #1;
        miss_detected = 1'b1;
        miss_address = ma;
        victim_dirty = dirty;
        victim_address = va;
        base = cyc;
        for (int i = 0; i < WORDS; i++) begin
            if (dirty) begin
                e.a = vbase + 16'(i << OFF);
                e.d = vsalt + 16'(i) * 16'h0111;
                e.c = timed ? 1 + i : -1;
                q_wr.push_back(e);
            end
            wa = mbase + 16'(i << OFF);
            e.a = wa;
            e.d = 16'h0;
            e.c = timed ? off + 1 + i : -1;
            q_rd.push_back(e);
            e.a = 16'(i);
            e.d = mfun(wa);
            e.c = timed ? off + 1 + i + L : -1;
            q_aw.push_back(e);
        end
        q_tag.push_back(timed ? off + WORDS + L + 1 : -1);
        @(negedge clk);
        chk("busy_in_miss_cycle", 32'(fsm_busy), 32'(1));
        if (!hold) begin
            @(posedge clk);
            #1;
            miss_detected = 1'b0;
            miss_address = 16'($urandom);
            victim_address = 16'($urandom);
            victim_dirty = 1'($urandom);
        end
    endtask

    task automatic finish_miss(input bit dirty, input int L, input bit timed, input bit hold);
        bit done;
        done = 1'b0;
        if (hold) begin
            for (int k = 0; k < 400 && !done; k++) begin
                @(negedge clk);
                if (write_tag_array) done = 1'b1;
            end
            @(posedge clk);
            #1;
            miss_detected = 1'b0;
        end
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (!fsm_busy) done = 1'b1;
        end
        if (!done) unexpected("busy_timeout");
        else if (timed && !hold)
            chk("busy_low_cycle", 32'(cyc - base), 32'((dirty ? WORDS : 0) + WORDS + L + 2));
        chk("expect_queues_drained", 32'(q_wr.size() + q_rd.size() + q_aw.size() + q_tag.size()), 32'(0));
    endtask

    task automatic do_miss(input logic [15:0] ma, input bit dirty, input logic [15:0] va,
                           input int L, input bit timed);
        start_miss(ma, dirty, va, L, timed, 1'b0);
        finish_miss(dirty, L, timed, 1'b0);
    endtask

    initial begin
        bit found;
        rst = 1'b0;
        miss_detected = 1'b0;
        miss_address = 16'h1234;
        victim_dirty = 1'b0;
        victim_address = 16'h0;
        memory_data = 16'h0;
        memory_data_valid = 1'b0;
        d4_miss = 1'b0; d4_dirty = 1'b0; d4_maddr = 16'h0; d4_vaddr = 16'h0;
        d4_valid = 1'b0; d4_mdata = 16'h0;
        #2;
        chk("rst_rd", 32'(mem_read_req), 32'(0));
        chk("rst_wr", 32'(mem_write_req), 32'(0));
        chk("rst_aw", 32'(write_data_array), 32'(0));
        chk("rst_tag", 32'(write_tag_array), 32'(0));
        chk("rst_idx", 32'(data_array_word_idx), 32'(0));
        chk("rst_wdata", 32'(memory_wdata), 32'(0));
        chk("rst_busy", 32'(fsm_busy), 32'(0));
        chk("rst_addr", 32'(memory_address), 32'(16'h1234));
        miss_detected = 1'b1;
        miss_address = 16'hBEEF;
        #1;
        chk("rst_busy_follows_miss", 32'(fsm_busy), 32'(1));
        chk("rst_addr_follows_miss", 32'(memory_address), 32'(16'hBEEF));
        miss_detected = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;

        vsalt = 16'($urandom);
        msalt = 16'($urandom);
        do_miss(16'h1234, 1'b0, 16'h0000, 4, 1'b1);
        do_miss(16'h9ABC, 1'b1, 16'h5678, 2, 1'b1);

        bubble = 1'b1;
        do_miss(16'h4242, 1'b0, 16'h0, 3, 1'b0);
        bubble = 1'b0;

        // Reset in the middle of the third array write of a fill.
        start_miss(16'h7770, 1'b0, 16'h0, 2, 1'b1, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #2;
            if (write_data_array && data_array_word_idx == 3'd2) found = 1'b1;
        end
        if (!found) unexpected("third_write_timeout");
        rst = 1'b0;
        #1;
        chk("midrst_rd", 32'(mem_read_req), 32'(0));
        chk("midrst_aw", 32'(write_data_array), 32'(0));
        chk("midrst_tag", 32'(write_tag_array), 32'(0));
        chk("midrst_busy", 32'(fsm_busy), 32'(0));
        q_wr.delete(); q_rd.delete(); q_aw.delete(); q_tag.delete(); q_pend.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        do_miss(16'h7770, 1'b1, 16'h3030, 3, 1'b1);

        // Miss held across the whole fill, then a stray valid while idle.
        start_miss(16'h2468, 1'b0, 16'h0, 2, 1'b1, 1'b1);
        finish_miss(1'b0, 2, 1'b1, 1'b1);
        stray = 1'b1;
        @(posedge clk);
        #2;
        stray = 1'b0;
        chk("stray_no_array_write", 32'(write_data_array), 32'(0));
        repeat (4) @(negedge clk);
        chk("stray_stays_idle", 32'(fsm_busy), 32'(0));

        for (int t = 0; t < 6; t++) begin
            vsalt = 16'($urandom);
            msalt = 16'($urandom);
            do_miss(16'($urandom), 1'($urandom), 16'($urandom), int'($urandom_range(1, 5)), 1'b1);
        end

        // Four-word line instance, memory latency 1.
        @(posedge clk);
        #1;
        d4_miss = 1'b1;
        d4_maddr = 16'h00F6;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            d4_miss = 1'b0;
            d4_valid = (c >= 2 && c <= 5);
            d4_mdata = 16'hC000 + 16'(c);
            @(negedge clk);
            if (c <= 4) begin
                chk("w4_rd", 32'(d4_rd), 32'(1));
                chk("w4_rd_addr", 32'(d4_addr), 32'(16'h00F0 + 16'((c - 1) * 2)));
            end else chk("w4_rd_done", 32'(d4_rd), 32'(0));
            if (c >= 2 && c <= 5) begin
                chk("w4_aw", 32'(d4_wda), 32'(1));
                chk("w4_idx", 32'(d4_idx), 32'(c - 2));
                chk("w4_fill", 32'(d4_fill), 32'(16'hC000 + 16'(c)));
            end
            chk("w4_tag", 32'(d4_tag), 32'(c == 6));
        end
        @(posedge clk);
        #1;
        d4_valid = 1'b0;
        @(negedge clk);
        chk("w4_idle", 32'(d4_busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
